// File: rtl/mem_pkg.sv
// Shared definitions for the data-side memory path of the MIPS core.
//   ld_type_e  : 3-bit load codes (opcode[2:0])
//   lu_state_e : load-unit FSM states
//   is_legal_type / is_aligned : load request qualification helpers
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TYPE_W = 3;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b011,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } ld_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lu_state_e;

    // Codes 010, 110 and 111 are reserved.
    function automatic logic is_legal_type(input logic [TYPE_W-1:0] t);
        case (t)
            LD_B, LD_H, LD_W, LD_BU, LD_HU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Natural alignment: words on 4 bytes, halfwords on 2, bytes anywhere.
    function automatic logic is_aligned(input logic [TYPE_W-1:0] t, input logic [1:0] a);
        case (t)
            LD_W:        return (a == 2'b00);
            LD_H, LD_HU: return (a[0] == 1'b0);
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_unit_if.sv
// Word-aligned read port between the load unit and data memory.
//   mem_req   : read request, held until acknowledged
//   mem_addr  : word address (low two bits zero)
//   mem_ack   : one-cycle acknowledge, mem_rdata valid in the same cycle
//   mem_rdata : read word
interface load_unit_if;
    import mem_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);

endinterface

// File: rtl/load_extract.sv
// Combinational little-endian byte/halfword select with sign/zero extension.
//   rdata    : word read from memory
//   a        : low address bits of the load
//   ld_type  : load code (ld_type_e)
//   result_c : extended load value
module load_extract
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        a,
    input  logic [TYPE_W-1:0] ld_type,
    output logic [DATA_W-1:0] result_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select; halfword lane ignores a[0] since it is aligned.
    always_comb begin
        byte_sel = rdata[{a, 3'b000} +: 8];
        half_sel = rdata[{a[1], 4'b0000} +: 16];
    end

    always_comb begin
        result_c = rdata;
        case (ld_type)
            LD_B:    result_c = {{24{byte_sel[7]}}, byte_sel};
            LD_H:    result_c = {{16{half_sel[15]}}, half_sel};
            LD_BU:   result_c = {24'h000000, byte_sel};
            LD_HU:   result_c = {16'h0000, half_sel};
            default: result_c = rdata;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// MEM-stage load controller: qualifies lb/lh/lw/lbu/lhu requests, issues a
// word-aligned read over a req/ack port, extends the result and stalls the
// pipeline until the load completes or is aborted.
//   clk, reset : clock, asynchronous active-low reset
//   ld_valid   : MEM stage holds a load
//   ld_type    : load code (opcode[2:0])
//   ld_addr    : byte address
//   stall      : combinational pipeline freeze
//   ld_data    : registered extended result
//   ld_done    : one-cycle success pulse
//   ld_err     : one-cycle abort pulse (misaligned, reserved type, timeout)
//   mem        : memory read port (master side)
module load_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [TYPE_W-1:0] ld_type,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              stall,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_done,
    output logic              ld_err,
    load_unit_if.master       mem
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lu_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] ext_c;

    load_extract u_extract (
        .rdata    (mem.mem_rdata),
        .a        (addr_q[1:0]),
        .ld_type  (type_q),
        .result_c (ext_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            type_q  <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-output logic; done/err are pulses set only on entry to DONE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        type_d  = type_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ld_valid) begin
                    if (is_legal_type(ld_type) && is_aligned(ld_type, ld_addr[1:0])) begin
                        state_d = WAIT;
                        addr_d  = ld_addr;
                        type_d  = ld_type;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (mem.mem_ack) begin
                    state_d = DONE;
                    data_d  = ext_c;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall        = ld_valid && (state_q != DONE);
    assign ld_data      = data_q;
    assign ld_done      = done_q;
    assign ld_err       = err_q;
    assign mem.mem_req  = req_q;
    assign mem.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: drives loads, answers the memory port with a
// programmable ack delay, and compares each completion against a scoreboard.
module tb_load_unit;
    import mem_pkg::*;

    localparam int unsigned TO = 16;
    localparam int unsigned BUDGET = 40;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ld_valid = 1'b0;
    logic [2:0]  ld_type = 3'b000;
    logic [31:0] ld_addr = 32'h0;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_done;
    logic        ld_err;

    load_unit_if bus ();

    load_unit #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_type  (ld_type),
        .ld_addr  (ld_addr),
        .stall    (stall),
        .ld_data  (ld_data),
        .ld_done  (ld_done),
        .ld_err   (ld_err),
        .mem      (bus.master)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];
    logic [31:0] model_data = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference extraction written with shifts and signed casts.
    function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] w;
        w = rd >> (8 * a[1:0]);
        case (t)
            3'b000:  return 32'($signed(w[7:0]));
            3'b001:  return 32'($signed(w[15:0]));
            3'b100:  return w & 32'h0000_00FF;
            3'b101:  return w & 32'h0000_FFFF;
            default: return rd;
        endcase
    endfunction

    // Issue one load starting at the current negedge (cycle 0). The memory
    // acks k cycles after mem_req rises. Returns at the negedge of the
    // following IDLE cycle with ld_valid low.
    task automatic do_load(input string tag, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] rd, input int k, input logic exp_err,
                           input logic [31:0] exp_data, input int exp_lat,
                           input int exp_req_cyc);
        int   req_cyc;
        logic done;
        logic addr_bad;
        exp_t e;
        sb.push_back('{err: exp_err, data: exp_data});
        ld_valid      = 1'b1;
        ld_type       = t;
        ld_addr       = a;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        req_cyc  = 0;
        done     = 1'b0;
        addr_bad = 1'b0;
        #1;
        chk({tag, " stall c0"}, 32'(stall), 32'd1);
        chk({tag, " req c0"}, 32'(bus.mem_req), 32'd0);
        for (int c = 1; c <= int'(BUDGET) && !done; c++) begin
            @(negedge clk);
            if (ld_done || ld_err) begin
                done = 1'b1;
                e = sb.pop_front();
                chk({tag, " latency"}, 32'(c), 32'(exp_lat));
                chk({tag, " ld_err"}, 32'(ld_err), 32'(e.err));
                chk({tag, " ld_done"}, 32'(ld_done), 32'(!e.err));
                chk({tag, " ld_data"}, ld_data, e.data);
                chk({tag, " stall done"}, 32'(stall), 32'd0);
                chk({tag, " req cycles"}, 32'(req_cyc), 32'(exp_req_cyc));
                chk({tag, " addr stable"}, 32'(addr_bad), 32'd0);
                chk({tag, " req low done"}, 32'(bus.mem_req), 32'd0);
            end else begin
                if (c == 1) chk({tag, " stall c1"}, 32'(stall), 32'd1);
                if (bus.mem_req) begin
                    req_cyc++;
                    if (bus.mem_addr !== (a & 32'hFFFF_FFFC)) addr_bad = 1'b1;
                end
                bus.mem_ack   = bus.mem_req && (req_cyc - 1 == k);
                bus.mem_rdata = bus.mem_ack ? rd : $urandom;
            end
        end
        if (!done) begin
            n_total++;
            $error("FAIL %s timeout: no ld_done/ld_err within %0d cycles", tag, BUDGET);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        ld_valid    = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk({tag, " pulse clear"}, {30'h0, ld_done, ld_err}, 32'd0);
    endtask

    initial begin
        logic [2:0]  t;
        logic [31:0] a, rd, exp;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;

        // Reset values; stall follows ld_valid while in reset.
        repeat (2) @(negedge clk);
        chk("rst ld_data", ld_data, 32'h0);
        chk("rst pulses", {30'h0, ld_done, ld_err}, 32'd0);
        chk("rst mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst stall lo", 32'(stall), 32'd0);
        ld_valid = 1'b1;
        #1 chk("rst stall hi", 32'(stall), 32'd1);
        ld_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed vectors.
        do_load("lw 0x10", LD_W, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 2, 1);
        do_load("lb 0x13", LD_B, 32'h13, 32'h80112233, 2, 1'b0, 32'hFFFFFF80, 4, 3);
        do_load("lbu 0x13", LD_BU, 32'h13, 32'h80112233, 1, 1'b0, 32'h00000080, 3, 2);
        do_load("lb 0x10", LD_B, 32'h10, 32'h80112233, 0, 1'b0, 32'h00000033, 2, 1);
        do_load("lh 0x2", LD_H, 32'h2, 32'h80011234, 3, 1'b0, 32'hFFFF8001, 5, 4);
        do_load("lhu 0x0", LD_HU, 32'h0, 32'h80011234, 0, 1'b0, 32'h00001234, 2, 1);
        model_data = 32'h00001234;

        // Immediate aborts keep the previous result.
        do_load("lw 0x6", LD_W, 32'h6, 32'h0, 0, 1'b1, model_data, 1, 0);
        do_load("type 010", 3'b010, 32'h10, 32'h0, 0, 1'b1, model_data, 1, 0);
        do_load("lh 0x1", LD_H, 32'h1, 32'h0, 0, 1'b1, model_data, 1, 0);

        // Timeout: no ack ever; then a late ack must be ignored.
        do_load("timeout", LD_W, 32'h40, 32'h0, 1000, 1'b1, model_data, int'(TO) + 1, int'(TO));
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("late ack pulses", {30'h0, ld_done, ld_err}, 32'd0);
        chk("late ack req", 32'(bus.mem_req), 32'd0);
        chk("late ack data", ld_data, model_data);
        do_load("lw after to", LD_W, 32'h44, 32'hCAFEF00D, 1, 1'b0, 32'hCAFEF00D, 3, 2);

        // Reset in the middle of WAIT, then the held load restarts.
        ld_valid = 1'b1;
        ld_type  = LD_W;
        ld_addr  = 32'h20;
        @(negedge clk);
        chk("pre-rst req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid-rst req", 32'(bus.mem_req), 32'd0);
        chk("mid-rst data", ld_data, 32'h0);
        chk("mid-rst pulses", {30'h0, ld_done, ld_err}, 32'd0);
        chk("mid-rst stall", 32'(stall), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        do_load("lw restart", LD_W, 32'h20, 32'h13579BDF, 1, 1'b0, 32'h13579BDF, 3, 2);

        // Randomised legal, aligned loads against the reference extractor.
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 4))
                0:       t = LD_B;
                1:       t = LD_H;
                2:       t = LD_W;
                3:       t = LD_BU;
                default: t = LD_HU;
            endcase
            a = $urandom & 32'h0000_0FFF;
            if (t == LD_W) a = a & 32'hFFFF_FFFC;
            if (t == LD_H || t == LD_HU) a = a & 32'hFFFF_FFFE;
            rd  = $urandom;
            exp = ref_load(t, a, rd);
            begin
                int k;
                k = int'($urandom_range(0, 3));
                do_load($sformatf("rand%0d", i), t, a, rd, k, 1'b0, exp, k + 2, k + 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_unit.md
# load_unit

Data-side load controller in the MEM stage of the pipelined MIPS core; it is the read-side counterpart of the sb/sh/sw store path into data memory. It accepts lb/lh/lw/lbu/lhu requests from the pipeline and issues word-aligned read requests to a variable-latency memory port over a req/ack handshake. It extracts and sign- or zero-extends the addressed byte or halfword, and stalls the pipeline until the result is ready. Misaligned accesses, reserved load types and memory timeouts are reported as a one-cycle error pulse.

## Interface
- TIMEOUT, 16: number of WAIT cycles without `mem_ack` before the load is aborted with an error (must be ≥ 1).
- clk  in  1  Clock. All state updates on the rising edge.
- reset  in  1  Asynchronous, active-low reset.
- ld_valid  in  1  The MEM stage holds a load. Held high until `stall` falls.
- ld_type  in  3  Load type, equal to opcode[2:0]: 000 lb, 001 lh, 011 lw, 100 lbu, 101 lhu. 010, 110 and 111 are reserved.
- ld_addr  in  32  Byte address, stable while `ld_valid` is high.
- stall  out  1  Freeze the pipeline. Combinational: `ld_valid && state != DONE`.
- ld_data  out  32  Extended load result, registered.
- ld_done  out  1  One-cycle pulse: `ld_data` is valid this cycle.
- ld_err  out  1  One-cycle pulse: the load is aborted (misaligned, reserved type or timeout).
- mem_req  out  1  Read request, registered, level-held until acknowledged.
- mem_addr  out  32  `{addr_q[31:2], 2'b00}`.
- mem_ack  in  1  One-cycle acknowledge. `mem_rdata` is valid in the same cycle.
- mem_rdata  in  32  Read word.

## Operation
- FSM states:
  - IDLE → WAIT: `ld_valid` is high, the type is legal and the address is aligned. Latch addr/type, set `mem_req`, clear the counter.
  - IDLE → DONE with the error flag set: `ld_valid` is high and the type is reserved or the address is misaligned. No `mem_req` is issued.
  - WAIT → DONE: `mem_ack` is high. Extract `mem_rdata` into `ld_data` and clear `mem_req`.
  - WAIT → DONE with the error flag set: the counter reaches TIMEOUT−1 with no ack. Clear `mem_req`; `ld_data` is unchanged.
  - DONE → IDLE, unconditionally. DONE drives `ld_done` (success) or `ld_err` (error), exactly one of them.
- Alignment rules: lw requires `addr[1:0]=00`; lh/lhu require `addr[0]=0`; lb/lbu accept any address.
- Extraction is little-endian:
  - Byte = `rdata[{a[1:0],3'b000} +: 8]`.
  - Halfword = `rdata[{a[1],4'b0000} +: 16]`.
  - lb/lh sign-extend to 32 bits; lbu/lhu zero-extend; lw passes the word through.
- `mem_ack` is ignored in IDLE and DONE. A late ack after a timeout has no effect.
- `ld_data` holds its value until the next successful completion.
- Reset values: state=IDLE, `mem_req`=0, `ld_data`=0, `ld_done`=0, `ld_err`=0, counter=0. `stall` follows `ld_valid` during reset.

## Timing
- Minimum latency: IDLE sees the load in cycle 0, `mem_req` is high in cycle 1 with ack in the same cycle, and DONE is in cycle 2. `stall` is high in cycles 0–1 and low in cycle 2.
- An ack k cycles after `mem_req` rises gives `ld_done` k+1 cycles later.
- The error path for misaligned or reserved loads takes 1 cycle: `ld_err` is asserted in cycle 1 and `stall` is high in cycle 0 only.
- Back-to-back loads incur a mandatory IDLE cycle after DONE.
- `mem_req` and `mem_addr` are stable for the whole of WAIT.
- When reset is asserted mid-WAIT, `mem_req` drops asynchronously and the in-flight load is discarded. With `ld_valid` still high after release, the load restarts from IDLE.

## Structure
- A shared package `mem_pkg` holds:
  - `ld_type_e`, the enum of the 3-bit load codes;
  - `lu_state_e`, the FSM state enum {IDLE, WAIT, DONE};
  - an alignment-check function.
- Sub-module `load_extract`: a combinational align/extend unit with ports (rdata, a[1:0], type) → 32-bit result. It is instantiated once, on the `mem_rdata` path.
- The timeout counter width is `$clog2(TIMEOUT)` with a minimum of 1.

## Test plan
- lw with addr 0x10, memory acking 1 cycle after the request with 0xDEADBEEF → `ld_done` in cycle 2, `ld_data`=0xDEADBEEF, `stall` high in cycles 0–1, `mem_addr`=0x10.
- lb at 0x13 with rdata 0x80112233 → 0xFFFFFF80. lbu at 0x13 → 0x00000080. lb at 0x10 → 0x00000033.
- lh at 0x2 with rdata 0x80011234 → 0xFFFF8001. lhu at 0x0 → 0x00001234.
- lw at 0x6, and separately `ld_type`=010 → `mem_req` never rises, `ld_err` pulses in cycle 1, `ld_data` keeps its previous value.
- TIMEOUT=16 with no ack → `mem_req` high in cycles 1–16, `ld_err` in cycle 17. An ack injected in cycle 18 is ignored, and the next lw completes normally.
- Reset driven low in the middle of WAIT → `mem_req`=0 immediately and all outputs at their reset values. After release with `ld_valid` high, a fresh `mem_req` appears and completes.
